irq_arbiter: RTL and testbench
==============================

Name: irq_arbiter

Overview:
Interrupt request controller sitting in front of the ID stage's interrupt coprocessor logic.
- Captures rising edges on external interrupt lines, applies a per-source mask, and arbitrates by fixed priority.
- Tracks nested in-service interrupts so only a strictly higher-priority source can preempt.
- Offers one locked request (ivld/inum) to the pipeline and holds it until the pipeline accepts it with `take`.

Parameters:
NIRQ, 4, number of interrupt sources; index NIRQ-1 has the highest priority.
NBIT_IRQ, 2, width of interrupt number; must equal clog2(NIRQ).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
en  in  1  pipeline enable; when 0, all state holds, including edge-detect history
irq_raw  in  NIRQ  raw interrupt lines, already synchronous to clk
irq_mask  in  NIRQ  1 = source enabled
take  in  1  pipeline has accepted the offered interrupt this cycle
ret  in  1  ERET retired this cycle
ivld  out  1  interrupt request valid (registered)
inum  out  NBIT_IRQ  number of the offered interrupt (registered); stable while ivld=1
pending  out  NIRQ  latched pending vector
in_service  out  NIRQ  in-service vector
busy  out  1  OR-reduce of in_service

Behaviour:
- Reset (rst=1 at a clock edge, overrides en): pending, in_service, edge history, ivld and inum go to 0; FSM goes to IDLE. A reset mid-request drops the request silently.
- Edge capture (en=1):
  - prev <= irq_raw.
  - A rising edge on bit i (irq_raw[i] & ~prev[i]) sets pending[i] at the next edge.
  - Edge detection ignores the mask; masked sources still latch pending.
- Eligibility:
  - Source i is eligible when pending[i] & irq_mask[i], and i > the index of the highest set in_service bit.
  - When in_service = 0, every pending, unmasked source is eligible.
- Selection: the highest eligible index wins.
- FSM (advances only when en=1):
  - IDLE: ivld=0. If any source is eligible, register inum = winner, set ivld=1 and go to REQ.
  - REQ: ivld=1 and inum held.
    - On take: clear pending[inum], set in_service[inum], deassert ivld, go to ACK.
    - Else if irq_mask[inum]=0: deassert ivld and return to IDLE; pending is kept.
    - A newly eligible higher-priority source does NOT replace inum while in REQ.
  - ACK: ivld=0 for exactly one enabled cycle, so the pipeline can commit EPC/IE. Then go to IDLE.
- Latency: an edge on irq_raw seen at enabled cycle t sets pending at t+1 and asserts ivld at t+2. After take, the earliest next ivld is 3 enabled cycles later.
- ret: clears the highest set bit of in_service. Ignored when in_service=0.
- Simultaneous events:
  - take and ret in the same cycle: ret clears the highest bit of the old in_service, then the take bit is set; both take effect.
  - take and a new edge on the same source: the new edge wins and pending stays 1.
  - take outside REQ: ignored, no state change; the bench flags it as a protocol error.
- Width rule: inum is the zero-extended index; no wrap-around. in_service can hold at most NIRQ nested levels by construction.

Decomposition:
- Core.vh: NIRQ and NBIT_IRQ (existing), plus IRQ_ARB_ST_NBIT and the state codes IRQ_ARB_ST_IDLE=0, IRQ_ARB_ST_REQ=1, IRQ_ARB_ST_ACK=2.
- Sub-module cmb_prio_enc (combinational): takes a NIRQ vector and returns {any, index of highest set bit}. It is instantiated twice: once for eligible requests and once for the top in_service bit.

Test Plan:
- Reset then a pulse on irq_raw[1] with mask=4'b1111 -> pending=4'b0010 one cycle later, ivld=1 and inum=1 two cycles later; hold take=0 for 5 cycles -> inum stays 1.
- Edges on bits 0 and 2 in the same cycle -> inum=2 offered. take -> in_service=4'b0100, pending=4'b0001. Source 0 is not offered until ret, then inum=0 appears 2 cycles after ret.
- While in_service=4'b0010, an edge on bit 3 -> offered (preemption) and in_service=4'b1010 after take. ret -> 4'b0010; second ret -> 4'b0000.
- In REQ with inum=2, drop irq_mask[2] -> ivld=0 next cycle, pending[2] stays 1. Restore the mask -> reoffered as inum=2.
- Hold en=0 across an edge on irq_raw[0], then raise en -> the edge is still captured; ivld=1 two enabled cycles later. take with en=0 -> no state change.
- Assert rst while in REQ with in_service=4'b0001 -> the next cycle shows all outputs 0 and the FSM in IDLE. take together with a fresh edge on the same source -> pending bit remains 1.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// Shared sizing and FSM state encoding for the interrupt arbiter.
package irq_arbiter_pkg;

  localparam int unsigned NIRQ            = 4;
  localparam int unsigned NBIT_IRQ        = 2;
  localparam int unsigned IRQ_ARB_ST_NBIT = 2;

  typedef enum logic [IRQ_ARB_ST_NBIT-1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StAck  = 2'd2
  } irq_arb_st_e;

endpackage

// File: rtl/cmb_prio_enc.sv
// Combinational priority encoder: reports whether any bit is set and the index of the highest one.
module cmb_prio_enc #(
  parameter int unsigned Width = 4,
  parameter int unsigned IdxW  = 2
) (
  input  logic [Width-1:0] vec_i,
  output logic             any_o,
  output logic [IdxW-1:0]  idx_o
);

  assign any_o = |vec_i;

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      if (vec_i[i]) begin
        idx_o = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Edge-capturing, fixed-priority interrupt arbiter with nested in-service tracking.
module irq_arbiter
  import irq_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NIRQ-1:0]     irq_raw,
  input  logic [NIRQ-1:0]     irq_mask,
  input  logic                take,
  input  logic                ret,
  output logic                ivld,
  output logic [NBIT_IRQ-1:0] inum,
  output logic [NIRQ-1:0]     pending,
  output logic [NIRQ-1:0]     in_service,
  output logic                busy
);

  irq_arb_st_e         state_q, state_d;
  logic [NIRQ-1:0]     prev_q, prev_d;
  logic [NIRQ-1:0]     pending_q, pending_d;
  logic [NIRQ-1:0]     in_service_q, in_service_d;
  logic                ivld_q, ivld_d;
  logic [NBIT_IRQ-1:0] inum_q, inum_d;

  logic [NIRQ-1:0]     rise;
  logic [NIRQ-1:0]     eligible;
  logic                elig_any;
  logic [NBIT_IRQ-1:0] elig_idx;
  logic                svc_any;
  logic [NBIT_IRQ-1:0] svc_idx;

  assign rise = irq_raw & ~prev_q;

  cmb_prio_enc #(
    .Width(NIRQ),
    .IdxW (NBIT_IRQ)
  ) u_svc_enc (
    .vec_i(in_service_q),
    .any_o(svc_any),
    .idx_o(svc_idx)
  );

  // Only sources strictly above the innermost in-service level may preempt.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      eligible[i] = pending_q[i] & irq_mask[i] & (~svc_any | (NBIT_IRQ'(i) > svc_idx));
    end
  end

  cmb_prio_enc #(
    .Width(NIRQ),
    .IdxW (NBIT_IRQ)
  ) u_elig_enc (
    .vec_i(eligible),
    .any_o(elig_any),
    .idx_o(elig_idx)
  );

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    pending_d    = pending_q;
    in_service_d = in_service_q;
    ivld_d       = ivld_q;
    inum_d       = inum_q;
    if (en) begin
      prev_d = irq_raw;
      // ret clears the old top level before a same-cycle take sets the new one.
      if (ret && svc_any) begin
        in_service_d[svc_idx] = 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (elig_any) begin
            state_d = StReq;
            ivld_d  = 1'b1;
            inum_d  = elig_idx;
          end
        end
        StReq: begin
          if (take) begin
            pending_d[inum_q]    = 1'b0;
            in_service_d[inum_q] = 1'b1;
            ivld_d               = 1'b0;
            state_d              = StAck;
          end else if (!irq_mask[inum_q]) begin
            ivld_d  = 1'b0;
            state_d = StIdle;
          end
        end
        StAck: begin
          state_d = StIdle;
        end
        default: begin
          ivld_d  = 1'b0;
          state_d = StIdle;
        end
      endcase
      // A fresh edge on the source being taken keeps it pending.
      pending_d = pending_d | rise;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      prev_q       <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      ivld_q       <= 1'b0;
      inum_q       <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      ivld_q       <= ivld_d;
      inum_q       <= inum_d;
    end
  end

  assign ivld       = ivld_q;
  assign inum       = inum_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign busy       = |in_service_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench: directed literal checks plus randomized traffic against a nesting-stack model.
module tb_irq_arbiter;
  import irq_arbiter_pkg::*;

  logic                clk = 1'b0;
  logic                rst, en, take, ret;
  logic [NIRQ-1:0]     irq_raw, irq_mask;
  logic                ivld, busy;
  logic [NBIT_IRQ-1:0] inum;
  logic [NIRQ-1:0]     pending, in_service;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  irq_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .irq_raw   (irq_raw),
    .irq_mask  (irq_mask),
    .take      (take),
    .ret       (ret),
    .ivld      (ivld),
    .inum      (inum),
    .pending   (pending),
    .in_service(in_service),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: pending as a bit set, in-service levels as a stack of source numbers.
  bit [NIRQ-1:0] m_prev, m_pend, m_rise;
  int            stk[$];
  bit            m_vld, m_gap;
  int            m_num, m_top, m_win;

  function automatic logic [NIRQ-1:0] m_svc();
    logic [NIRQ-1:0] v = '0;
    foreach (stk[k]) v[stk[k]] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_prev = '0; m_pend = '0; stk.delete();
      m_vld = 1'b0; m_gap = 1'b0; m_num = 0;
    end else if (en) begin
      m_rise = irq_raw & ~m_prev;
      m_prev = irq_raw;
      m_top  = (stk.size() > 0) ? stk[stk.size()-1] : -1;
      m_win  = -1;
      for (int i = NIRQ - 1; i >= 0; i--)
        if (m_win < 0 && m_pend[i] && irq_mask[i] && i > m_top) m_win = i;
      if (ret && stk.size() > 0) void'(stk.pop_back());
      if (m_vld && take) begin
        m_pend[m_num] = 1'b0;
        stk.push_back(m_num);
        m_vld = 1'b0;
        m_gap = 1'b1;
      end else if (m_vld && !irq_mask[m_num]) begin
        m_vld = 1'b0;
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (!m_vld && m_win >= 0) begin
        m_vld = 1'b1;
        m_num = m_win;
      end
      m_pend = m_pend | m_rise;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ivld", int'(ivld), int'(m_vld));
      if (m_vld) chk("cyc_inum", int'(inum), m_num);
      chk("cyc_pending", int'(pending), int'(m_pend));
      chk("cyc_in_service", int'(in_service), int'(m_svc()));
      chk("cyc_busy", int'(busy), int'(stk.size() > 0));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; take = 1'b0; ret = 1'b0;
    irq_raw = '0; irq_mask = 4'b1111;
    tick(2);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_ivld", int'(ivld), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_in_service", int'(in_service), 0);
    chk("rst_busy", int'(busy), 0);

    // Single edge latency and hold while not taken
    irq_raw = 4'b0010; tick();
    chk("t1_pending", int'(pending), 4'b0010);
    chk("t1_ivld_early", int'(ivld), 0);
    irq_raw = '0; tick();
    chk("t1_ivld", int'(ivld), 1);
    chk("t1_inum", int'(inum), 1);
    tick(5);
    chk("t1_inum_held", int'(inum), 1);
    take = 1'b1; tick(); take = 1'b0;
    chk("t1_svc", int'(in_service), 4'b0010);
    chk("t1_pend_clr", int'(pending), 0);
    tick();
    ret = 1'b1; tick(); ret = 1'b0;
    chk("t1_ret", int'(in_service), 0);

    // Two simultaneous edges, lower one blocked until ret
    irq_raw = 4'b0101; tick(); irq_raw = '0; tick();
    chk("t2_inum", int'(inum), 2);
    take = 1'b1; tick(); take = 1'b0;
    chk("t2_svc", int'(in_service), 4'b0100);
    chk("t2_pend", int'(pending), 4'b0001);
    tick(3);
    chk("t2_blocked", int'(ivld), 0);
    ret = 1'b1; tick(); ret = 1'b0;
    chk("t2_after_ret", int'(ivld), 0);
    tick();
    chk("t2_ivld0", int'(ivld), 1);
    chk("t2_inum0", int'(inum), 0);
    take = 1'b1; tick(); take = 1'b0; tick();
    ret = 1'b1; tick(); ret = 1'b0;

    // Preemption by a higher source
    irq_raw = 4'b0010; tick(); irq_raw = '0; tick();
    take = 1'b1; tick(); take = 1'b0; tick();
    irq_raw = 4'b1000; tick(); irq_raw = '0; tick();
    chk("t3_preempt_ivld", int'(ivld), 1);
    chk("t3_preempt_inum", int'(inum), 3);
    take = 1'b1; tick(); take = 1'b0;
    chk("t3_nested", int'(in_service), 4'b1010);
    tick();
    ret = 1'b1; tick();
    chk("t3_ret1", int'(in_service), 4'b0010);
    tick(); ret = 1'b0;
    chk("t3_ret2", int'(in_service), 4'b0000);

    // Mask drop while offered
    irq_raw = 4'b0100; tick(); irq_raw = '0; tick();
    chk("t4_inum", int'(inum), 2);
    irq_mask = 4'b1011; tick();
    chk("t4_drop", int'(ivld), 0);
    chk("t4_pend_kept", int'(pending), 4'b0100);
    tick(2);
    irq_mask = 4'b1111; tick();
    chk("t4_reoffer", int'(ivld), 1);
    chk("t4_reoffer_num", int'(inum), 2);
    take = 1'b1; tick(); take = 1'b0; tick();
    ret = 1'b1; tick(); ret = 1'b0;

    // Enable gating
    en = 1'b0; irq_raw = 4'b0001; tick(2);
    chk("t5_hold", int'(pending), 0);
    en = 1'b1; tick();
    chk("t5_capture", int'(pending), 4'b0001);
    tick();
    chk("t5_ivld", int'(ivld), 1);
    en = 1'b0; take = 1'b1; tick(2);
    chk("t5_take_gated", int'(in_service), 0);
    chk("t5_ivld_kept", int'(ivld), 1);
    take = 1'b0; en = 1'b1;
    take = 1'b1; tick(); take = 1'b0; irq_raw = '0; tick();
    chk("t5_svc", int'(in_service), 4'b0001);

    // Reset mid-request
    irq_raw = 4'b0100; tick(); irq_raw = '0; tick();
    chk("t6_req", int'(ivld), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_ivld", int'(ivld), 0);
    chk("t6_rst_inum", int'(inum), 0);
    chk("t6_rst_svc", int'(in_service), 0);
    chk("t6_rst_pend", int'(pending), 0);
    // Take coinciding with a fresh edge on the same source
    irq_raw = 4'b0010; tick(); irq_raw = '0; tick();
    irq_raw = 4'b0010; take = 1'b1; tick(); take = 1'b0; irq_raw = '0;
    chk("t6_pend_stays", int'(pending), 4'b0010);
    chk("t6_svc", int'(in_service), 4'b0010);
    tick();
    ret = 1'b1; tick(); ret = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      en       = ($urandom_range(0, 9) != 0);
      irq_raw  = NIRQ'($urandom) & NIRQ'($urandom) & NIRQ'($urandom);
      irq_mask = ($urandom_range(0, 7) == 0) ? NIRQ'($urandom) : 4'b1111;
      take     = m_vld && ($urandom_range(0, 2) == 0);
      ret      = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
